// File: rtl/vae_score_sequencer.sv
// vae_score_sequencer
// Holds one N_FEAT-feature sample and streams it into the forward VAE datapath.
// It then waits for the datapath to finish and captures the sigmoid reconstructions.
// Finally it scores the squared reconstruction error against a programmable threshold.
module vae_score_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int N_FEAT     = 9,
    parameter int TIMEOUT    = 63
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [3:0]                   wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         go,
    input  logic [31:0]                  threshold,
    output logic                         ready,
    output logic                         vae_start,
    output logic                         vae_clr,
    output logic [DATA_WIDTH-1:0]        xj,
    output logic [3:0]                   feat_idx,
    input  logic                         vae_done,
    input  logic [N_FEAT*DATA_WIDTH-1:0] a3_bus,
    output logic [31:0]                  score,
    output logic                         anomaly,
    output logic                         score_valid,
    output logic                         timeout_err
);
    localparam int DW   = DATA_WIDTH;
    localparam int FRAC = 10;
    localparam int SQW  = 2 * DW + 2;
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam logic [3:0]    LAST_IDX  = 4'(N_FEAT - 1);
    localparam logic [3:0]    ADDR_LIM  = 4'(N_FEAT);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_FEED, S_WAIT, S_CAPTURE, S_SCORE, S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      cnt_reg;
    logic [TW-1:0]   tmo_reg;
    logic [DW-1:0]   x_ram   [N_FEAT];
    logic [DW-1:0]   a3_reg  [N_FEAT];
    logic [DW-1:0]   a3_vec  [N_FEAT];
    logic [31:0]     acc_reg;
    logic [31:0]     score_reg;
    logic            anomaly_reg;

    logic signed [DW-1:0] a3_sel, x_sel;
    logic signed [DW:0]   diff;
    logic [SQW-1:0]       sq;
    logic [31:0]          term, acc_sum;

    // Unpack the reconstruction bus; a3_1 sits in the least significant slice.
    genvar gi;
    generate
        for (gi = 0; gi < N_FEAT; gi++) begin : g_unpack
            assign a3_vec[gi] = a3_bus[gi*DW +: DW];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_reg <= S_IDLE;
        else      state_reg <= state_next;
    end

    // Next-state and Moore/Mealy outputs; outputs default to their idle-zero values.
    always_comb begin
        state_next  = state_reg;
        ready       = 1'b0;
        vae_start   = 1'b0;
        vae_clr     = 1'b0;
        timeout_err = 1'b0;
        score_valid = 1'b0;
        xj          = '0;
        feat_idx    = '0;
        case (state_reg)
            S_IDLE: begin
                ready = 1'b1;
                if (go) state_next = S_START;
            end
            S_START: begin
                vae_start  = 1'b1;
                state_next = S_FEED;
            end
            S_FEED: begin
                xj       = x_ram[cnt_reg];
                feat_idx = cnt_reg;
                if (cnt_reg == LAST_IDX) state_next = S_WAIT;
            end
            S_WAIT: begin
                // A done seen in the same cycle as the limit still counts as success.
                if (vae_done) begin
                    state_next = S_CAPTURE;
                end else if (tmo_reg == TMO_LIMIT) begin
                    vae_clr     = 1'b1;
                    timeout_err = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            S_CAPTURE: state_next = S_SCORE;
            S_SCORE: begin
                if (cnt_reg == LAST_IDX) state_next = S_DONE;
            end
            S_DONE: begin
                score_valid = 1'b1;
                state_next  = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Feature index for FEED/SCORE, plus cycles-since-vae_start for the timeout.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg <= '0;
            tmo_reg <= '0;
        end else begin
            case (state_reg)
                S_START: begin
                    cnt_reg <= '0;
                    tmo_reg <= TW'(1);
                end
                S_FEED: begin
                    cnt_reg <= (cnt_reg == LAST_IDX) ? 4'd0 : cnt_reg + 4'd1;
                    tmo_reg <= tmo_reg + TW'(1);
                end
                S_WAIT: begin
                    cnt_reg <= '0;
                    tmo_reg <= tmo_reg + TW'(1);
                end
                S_SCORE: cnt_reg <= (cnt_reg == LAST_IDX) ? 4'd0 : cnt_reg + 4'd1;
                default: cnt_reg <= '0;
            endcase
        end
    end

    // Sample store: written only while idle, so a write beside go lands before the run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_FEAT; i++) x_ram[i] <= '0;
        end else if (state_reg == S_IDLE && wr_en && wr_addr < ADDR_LIM) begin
            x_ram[wr_addr] <= wr_data;
        end
    end

    // Latch the reconstructions once the datapath reports done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_FEAT; i++) a3_reg[i] <= '0;
        end else if (state_reg == S_CAPTURE) begin
            for (int i = 0; i < N_FEAT; i++) a3_reg[i] <= a3_vec[i];
        end
    end

    // One error term per SCORE cycle: (a3_i - x_i)^2 scaled back by the fraction bits.
    always_comb begin
        a3_sel  = a3_reg[cnt_reg];
        x_sel   = x_ram[cnt_reg];
        diff    = $signed({a3_sel[DW-1], a3_sel}) - $signed({x_sel[DW-1], x_sel});
        sq      = SQW'(diff) * SQW'(diff);
        term    = 32'(sq >> FRAC);
        acc_sum = acc_reg + term;
    end

    // Accumulator; the result registers load on the last term so they are stable during DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_reg     <= '0;
            score_reg   <= '0;
            anomaly_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_START: acc_reg <= '0;
                S_SCORE: begin
                    acc_reg <= acc_sum;
                    if (cnt_reg == LAST_IDX) begin
                        score_reg   <= acc_sum;
                        anomaly_reg <= (acc_sum > threshold);
                    end
                end
                default: ;
            endcase
        end
    end

    assign score   = score_reg;
    assign anomaly = anomaly_reg;

endmodule
